// File: rtl/ic7402_nor_pkg.sv
// Shared constants for the ic7402_nor quad-NOR block.
//   GATES_DEF : default number of independent 2-input NOR gates
//   CNT_W_DEF : default width of each per-gate transition counter
//   sel_w()   : width of the counter select port, max(1, clog2(gates))
package ic7402_nor_pkg;

  localparam int GATES_DEF = 4;
  localparam int CNT_W_DEF = 16;

  function automatic int sel_w(input int gates);
    return (gates > 1) ? $clog2(gates) : 1;
  endfunction

endpackage

// File: rtl/ic7402_nor_tcnt.sv
// Per-gate saturating transition counter.
//   clk : clock, rising edge
//   rst : synchronous active-high reset, clears the count
//   clr : synchronous clear; it has priority over inc
//   inc : count one transition this edge
//   cnt : current count, holds at all ones instead of wrapping
module ic7402_nor_tcnt
  import ic7402_nor_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (inc && (cnt != {CNT_W{1'b1}}))
      cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/ic7402_nor.sv
// Parameterized 7402-style NOR gate array with registered outputs and
// optional per-gate output-transition statistics.
//   clk, rst : clock and synchronous active-high reset
//   a, b     : NOR inputs, one bit per gate
//   y        : combinational NOR result (independent of clk/rst)
//   y_q      : y registered on each rising edge, resets to all ones
//   cnt_sel  : gate whose transition counter drives cnt_out
//   cnt_clr  : synchronous clear of all counters
//   cnt_out  : selected count, 0 for an out-of-range select
// Define IC7402_NOR_STATS_EN to build the counters; without it cnt_sel and
// cnt_clr are ignored and cnt_out is tied to 0.
module ic7402_nor
  import ic7402_nor_pkg::*;
#(
  parameter int GATES = GATES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [GATES-1:0]          a,
  input  logic [GATES-1:0]          b,
  output logic [GATES-1:0]          y,
  output logic [GATES-1:0]          y_q,
  input  logic [sel_w(GATES)-1:0]   cnt_sel,
  input  logic                      cnt_clr,
  output logic [CNT_W-1:0]          cnt_out
);

  // A 1 on either input forces 0 even if the other input is X/Z.
  assign y = ~(a | b);

  always_ff @(posedge clk) begin
    if (rst)
      y_q <= '1;
    else
      y_q <= y;
  end

`ifdef IC7402_NOR_STATS_EN
  // The first edge after reset compares a fresh sample against the reset
  // value of y_q rather than a real previous output, so it is not counted.
  logic skip;

  always_ff @(posedge clk) begin
    if (rst)
      skip <= 1'b1;
    else
      skip <= 1'b0;
  end

  logic [GATES-1:0][CNT_W-1:0] cnt;

  for (genvar g = 0; g < GATES; g++) begin : g_cnt
    ic7402_nor_tcnt #(.CNT_W(CNT_W)) u_tcnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc ((y[g] ^ y_q[g]) & ~skip),
      .cnt (cnt[g])
    );
  end

  always_comb begin
    cnt_out = '0;
    for (int i = 0; i < GATES; i++)
      if (int'(cnt_sel) == i)
        cnt_out = cnt[i];
  end
`else
  logic unused_stats;
  assign unused_stats = ^{cnt_sel, cnt_clr};
  assign cnt_out = '0;
`endif

endmodule

// File: tb/tb_ic7402_nor.sv
module tb_ic7402_nor;

  logic        clk = 1'b0;
  logic        run = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  a = '0, b = '0;
  logic [1:0]  sel = '0, sel2 = '0;
  logic        clr = 1'b0;
  logic [3:0]  y, yq;
  logic [2:0]  y2, yq2;
  logic [15:0] co;
  logic [1:0]  co2;

  int total = 0;
  int passed = 0;

  // Reference model: previous registered output, raw transition totals
  // per gate, and whether the next edge directly follows a reset.
  logic [3:0] m_yq = '1;
  int         m_cnt [4] = '{0, 0, 0, 0};
  bit         m_after_rst = 1'b1;

  always #5 if (run) clk = ~clk; else clk = 1'b0;

  ic7402_nor #(.GATES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .y(y), .y_q(yq),
    .cnt_sel(sel), .cnt_clr(clr), .cnt_out(co)
  );

  // Three gates so that select value 3 is out of range; 2-bit counters.
  ic7402_nor #(.GATES(3), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .a(a[2:0]), .b(b[2:0]), .y(y2), .y_q(yq2),
    .cnt_sel(sel2), .cnt_clr(clr), .cnt_out(co2)
  );

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  function automatic logic nor_ref(input logic x, input logic z);
    if (x === 1'b1 || z === 1'b1) return 1'b0;
    if (x === 1'b0 && z === 1'b0) return 1'b1;
    return 1'bx;
  endfunction

  function automatic logic [3:0] y_ref();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = nor_ref(a[i], b[i]);
    return r;
  endfunction

  // Expected counter read for gate i given the counter's saturation cap.
  function automatic int cnt_ref(input int i, input int gates, input int cap);
`ifdef IC7402_NOR_STATS_EN
    if (i >= gates) return 0;
    return (m_cnt[i] > cap) ? cap : m_cnt[i];
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    logic [3:0] ny;
    @(posedge clk);
    if (rst) begin
      m_yq = '1;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_after_rst = 1'b1;
    end else begin
      ny = y_ref();
      for (int i = 0; i < 4; i++) begin
        if (clr) m_cnt[i] = 0;
        else if (!m_after_rst && ny[i] != m_yq[i]) m_cnt[i]++;
      end
      m_yq = ny;
      m_after_rst = 1'b0;
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":y"}, 32'(y), 32'(y_ref()));
    chk({tag, ":y_q"}, 32'(yq), 32'(m_yq));
    chk({tag, ":y_q_sat"}, 32'(yq2), 32'(m_yq[2:0]));
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      sel2 = 2'(s);
      #1;
      chk($sformatf("%s:cnt%0d", tag, s), 32'(co), 32'(cnt_ref(s, 4, 65535)));
      chk($sformatf("%s:cnt_sat%0d", tag, s), 32'(co2), 32'(cnt_ref(s, 3, 3)));
    end
  endtask

  initial begin
    // Combinational behaviour with the clock stopped.
    a = 4'b0000; b = 4'b0000; #25;
    chk("comb_00_y0", 32'(y[0]), 32'd1);
    a = 4'b1111; b = 4'b1111; #25;
    chk("comb_11", 32'(y), 32'h0);
    a = 4'b1111; b = 4'b0000; #25;
    chk("comb_10", 32'(y), 32'h0);
    a = 4'b0000; b = 4'b1111; #25;
    chk("comb_01", 32'(y), 32'h0);
    a = 4'b1111; b = 4'bxxxx; #25;
    chk("comb_1x", 32'(y), 32'h0);
    chk("comb_1x_sat", 32'(y2), 32'h0);
    a = 4'b0101; b = 4'b0000; #25;
    chk("comb_mix", 32'(y), 32'hA);

    // Reset, then a first post-reset edge that matches the reset value.
    a = '0; b = '0; run = 1'b1; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_all("reset");
    tick();
    check_all("first_edge");
    a = 4'b0001;
    tick();
    check_all("a0001");
    chk("a0001_yq", 32'(yq), 32'hE);

    // Toggle gate 2 ten times after a clean clear.
    a = '0; clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 10; k++) begin
      a[2] = ~a[2];
      tick();
    end
    check_all("toggle10");
    sel = 2'd2; sel2 = 2'd2; #1;
    chk("toggle10_g2", 32'(co), 32'(cnt_ref(2, 4, 65535)));
    chk("toggle10_sat", 32'(co2), 32'(cnt_ref(2, 3, 3)));

    // Clear coinciding with a transition.
    a[1] = ~a[1]; clr = 1'b1;
    tick();
    clr = 1'b0;
    check_all("clr_vs_trans");

    // Reset in the middle of toggling; next edge differs but is not counted.
    a[3] = ~a[3];
    tick();
    a[3] = ~a[3]; rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all("mid_rst");
    a[3] = ~a[3];
    tick();
    check_all("post_rst_1st");
    a[3] = ~a[3];
    tick();
    check_all("post_rst_2nd");

    // Randomized traffic with occasional clears and resets.
    for (int k = 0; k < 60; k++) begin
      a = 4'($urandom);
      b = 4'($urandom) & 4'($urandom);
      clr = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 19) == 0);
      tick();
      clr = 1'b0; rst = 1'b0;
      check_all($sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ic7402_nor.md
IC7402_NOR -- requirements
Module: ic7402_nor

Interface
REQ-001 SHALL have parameter GATES, default 4: number of independent 2-input NOR gates (1..16).
REQ-002 SHALL have parameter CNT_W, default 16: width of each transition counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, all state on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port a, input, GATES bits: NOR input A, one bit per gate.
REQ-006 SHALL have port b, input, GATES bits: NOR input B, one bit per gate.
REQ-007 SHALL have port y, output, GATES bits: combinational NOR result.
REQ-008 SHALL have port y_q, output, GATES bits: registered copy of y.
REQ-009 SHALL have port cnt_sel, input, max(1,clog2(GATES)) bits: selects the gate whose counter drives cnt_out.
REQ-010 SHALL have port cnt_clr, input, 1 bit: clears all transition counters.
REQ-011 SHALL have port cnt_out, output, CNT_W bits: transition count of the gate selected by cnt_sel.

Function
REQ-012 SHALL drive y[i] = NOT(a[i] OR b[i]) for every gate, purely combinational, with no dependence on clk or rst.
REQ-013 SHALL drive y[i] = 0 whenever a[i] or b[i] is 1, even if the other input is X/Z; y[i] = 1 only when both inputs are 0.
REQ-014 SHALL sample y into y_q on every rising clk edge when rst is low, giving one cycle of latency.
REQ-015 SHALL count a transition for gate i when the newly sampled y[i] differs from the current y_q[i].
REQ-016 SHALL saturate each counter at 2^CNT_W-1 with no wrap-around.
REQ-017 SHALL clear all counters to 0 on a cnt_clr edge; clear SHALL win over a simultaneous transition in the same cycle.
REQ-018 SHALL drive cnt_out combinationally from the selected counter; a cnt_sel value >= GATES SHALL read 0.
REQ-019 SHALL show cnt_out = 0 in the cycle after a clear.

Reset
REQ-020 SHALL set y_q to all ones (the NOR of all-zero inputs) on rst high at a clk edge.
REQ-021 SHALL set all counters to 0 on rst high at a clk edge.
REQ-022 SHALL leave y unaffected by rst.
REQ-023 SHALL not count, for a reset applied mid-operation, the difference between the reset value of y_q and the first post-reset sample; counting resumes from the second post-reset edge.

Configuration
REQ-024 SHALL include the counters, cnt_sel, cnt_clr and cnt_out when macro IC7402_NOR_STATS_EN is defined.
REQ-025 SHALL omit all counter logic when IC7402_NOR_STATS_EN is undefined: cnt_sel and cnt_clr ignored, cnt_out tied to 0, and y and y_q behaviour unchanged.

Structure
REQ-026 SHALL place the GATES and CNT_W defaults and the counter-width constant in package ic7402_nor_pkg.
REQ-027 SHALL implement one per-gate saturating transition counter as sub-module ic7402_nor_tcnt, instantiated GATES times.

Verification
REQ-028 SHALL check: a=0,b=0 on gate 0 -> y[0]=1 within 25 ns, without any clock edge.
REQ-029 SHALL check: a=1,b=1 -> y=0; a=1,b=0 -> y=0; a=0,b=1 -> y=0, each 25 ns after the change; a=1,b=X -> y=0.
REQ-030 SHALL check: after rst, y_q=4'b1111 and cnt_out=0; then a=4'b0001 with b=0 -> y_q=4'b1110 one clk later, and cnt_sel=0 reads 1 (the first post-reset edge is not counted under REQ-023 because it matches the reset value).
REQ-031 SHALL check: toggle a[2] every cycle for 10 cycles -> cnt_sel=2 reads 10 and other gates read 0; with CNT_W=2, 10 toggles -> reads 3 (saturated).
REQ-032 SHALL check: cnt_clr asserted in the same cycle as a transition -> cnt_out=0 next cycle; rst mid-toggle -> all counters 0 and y_q=all ones.
REQ-033 SHALL check: build without IC7402_NOR_STATS_EN -> cnt_out=0 under toggling, with y and y_q identical to the stats build.
